// File: rtl/rr_arbiter_4ch_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_arbiter_4ch_pkg
// Purpose  : Shared constants, state type and rotate helper for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arbiter_4ch_pkg;

    localparam int NUM_REQ          = 4;
    localparam int IDX_W            = 2;
    localparam int HOLD_MAX_DEFAULT = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Requester 'sh' lands at bit 0 of the result.
    function automatic logic [NUM_REQ-1:0] rot_right(
        input logic [NUM_REQ-1:0] v,
        input logic [IDX_W-1:0]   sh
    );
        logic [2*NUM_REQ-1:0] w_dbl;
        w_dbl = {v, v} >> sh;
        return w_dbl[NUM_REQ-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_4ch_prio_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : priority_encoder_4bit
// Purpose  : 4-bit lowest-index-first priority encoder with valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_4bit (
    input  logic [3:0] req_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 2'd0;
        valid_o = 1'b1;
        if (req_i[0]) begin
            idx_o = 2'd0;
        end else if (req_i[1]) begin
            idx_o = 2'd1;
        end else if (req_i[2]) begin
            idx_o = 2'd2;
        end else if (req_i[3]) begin
            idx_o = 2'd3;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4ch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_arbiter_4ch
// Purpose  : Four-way round-robin arbiter with grant hold and watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_4ch
    import rr_arbiter_4ch_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [3:0]   req_i,
    input  logic         done_i,
    output logic [3:0]   gnt_o,
    output logic [1:0]   gnt_idx_o,
    output logic         busy_o,
    output logic         timeout_o
);

    localparam logic [CNT_W-1:0] C_HOLD_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_e               state_q,   state_d;
    logic [IDX_W-1:0]     ptr_q,     ptr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_idx_rot;
    logic                 w_valid;
    logic [IDX_W-1:0]     w_winner;
    logic                 w_wdog_exp;

    assign w_rot    = rot_right(req_i, ptr_q);
    assign w_winner = w_idx_rot + ptr_q;

    priority_encoder_4bit u_prio_enc (
        .req_i   (w_rot),
        .idx_o   (w_idx_rot),
        .valid_o (w_valid)
    );

    assign w_wdog_exp = (HOLD_MAX != 0) && (cnt_q == C_HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    state_d   = ST_GRANT;
                    gnt_d     = 4'b0001 << w_winner;
                    gnt_idx_d = w_winner;
                    cnt_d     = '0;
                end
            end
            ST_GRANT: begin
                if (cnt_q != C_HOLD_SAT) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
                // Exit reasons are prioritised: done, withdraw, watchdog.
                if (done_i || !req_i[gnt_idx_q] || w_wdog_exp) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    ptr_d     = gnt_idx_q + 2'd1;
                    timeout_d = !done_i && req_i[gnt_idx_q];
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign busy_o    = (state_q == ST_GRANT);
    assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4ch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rr_arbiter_4ch
// Purpose  : Directed self-checking bench for rr_arbiter_4ch (HOLD_MAX = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4ch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int vectors   = 0;
    int miscompares = 0;

    rr_arbiter_4ch #(
        .HOLD_MAX (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] e_gnt,
                               input logic [1:0] e_idx, input logic e_busy,
                               input logic e_to);
        chk({tag, ".gnt"},     gnt,             e_gnt);
        chk({tag, ".idx"},     {2'b00, gnt_idx}, {2'b00, e_idx});
        chk({tag, ".busy"},    {3'b000, busy},   {3'b000, e_busy});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, e_to});
    endtask

    // Expects grant w visible now; completes it with done three cycles in
    // and leaves the bench in the dead cycle that follows.
    task automatic serve(input string tag, input logic [1:0] w);
        check_state({tag, ".grant"}, 4'b0001 << w, w, 1'b1, 1'b0);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_state({tag, ".idle"}, 4'b0000, w, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;

        tick();
        tick();
        check_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        rst_n = 1'b1;
        tick();
        serve("rr0", 2'd0);
        tick();
        serve("rr1", 2'd1);
        tick();
        serve("rr2", 2'd2);
        tick();
        serve("rr3", 2'd3);
        tick();
        serve("rr0b", 2'd0);

        // ptr = 1 now
        req = 4'b0110;
        tick();
        serve("pre1", 2'd1);
        tick();
        serve("pre2", 2'd2);
        req = 4'b1001;
        tick();
        serve("wrap3", 2'd3);
        tick();
        serve("wrap0", 2'd0);

        req = 4'b0010;
        tick();
        check_state("wd.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        req = 4'b0000;
        tick();
        check_state("wd.exit", 4'b0000, 2'd1, 1'b0, 1'b0);
        req = 4'b1111;
        tick();
        serve("wd.ptr2", 2'd2);

        // ptr = 3: lone request on 2 runs into the watchdog
        req = 4'b0100;
        tick();
        check_state("wdog.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_state("wdog.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        tick();
        check_state("wdog.revoke", 4'b0000, 2'd2, 1'b0, 1'b1);
        tick();
        check_state("wdog.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check_state("wdog.done_wins", 4'b0000, 2'd2, 1'b0, 1'b0);

        // ptr = 3
        req = 4'b0010;
        tick();
        check_state("mid.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        check_state("mid.reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        check_state("mid.restart", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
